// File: rtl/packet_group_sequencer.sv
// Packet/group sequencer: passes a DW-bit stream through with zero latency, marks TLAST
// every size_lat beats, and steers groups of grp_lat packets into two ping-pong buffers.
module packet_group_sequencer #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [31:0]   PACKET_SIZE,
  input  logic [31:0]   PP_GROUP,
  input  logic          ENABLE,
  input  logic [1:0]    BUF_RELEASE,
  input  logic [DW-1:0] S_AXIS_TDATA,
  input  logic          S_AXIS_TVALID,
  output logic          S_AXIS_TREADY,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic          M_AXIS_TVALID,
  output logic          M_AXIS_TLAST,
  input  logic          M_AXIS_TREADY,
  output logic          PP_SEL,
  output logic [1:0]    BUF_FULL,
  output logic          GROUP_DONE,
  output logic          BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_BUF = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] beat_cnt_reg, beat_cnt_next;
  logic [31:0] pkt_cnt_reg, pkt_cnt_next;
  logic [31:0] size_lat_reg, size_lat_next;
  logic [31:0] grp_lat_reg, grp_lat_next;
  logic        pp_sel_reg, pp_sel_next;
  logic [1:0]  buf_full_reg, buf_full_next;
  logic        group_done_reg;

  logic        run, beat, last_beat, group_end, latch_cfg, pp_other;
  logic [1:0]  buf_set;
  logic [31:0] size_in, grp_in;

  assign size_in  = (PACKET_SIZE == 32'd0) ? 32'd1 : PACKET_SIZE;
  assign grp_in   = (PP_GROUP == 32'd0) ? 32'd1 : PP_GROUP;
  assign run      = (state_reg == ST_RUN);
  assign pp_other = ~pp_sel_reg;

  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TVALID = S_AXIS_TVALID & run;
  assign S_AXIS_TREADY = M_AXIS_TREADY & run;
  assign M_AXIS_TLAST  = run & (beat_cnt_reg == size_lat_reg - 32'd1);

  assign beat      = S_AXIS_TVALID & M_AXIS_TREADY & run;
  assign last_beat = beat & M_AXIS_TLAST;
  assign group_end = last_beat & (pkt_cnt_reg == grp_lat_reg - 32'd1);

  // Completion of a group takes priority over a release of the same buffer.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      assign buf_set[gi]       = group_end & (pp_sel_reg == (gi != 0));
      assign buf_full_next[gi] = buf_set[gi] | (buf_full_reg[gi] & ~BUF_RELEASE[gi]);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    latch_cfg  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ENABLE) begin
          if (buf_full_reg[pp_sel_reg]) begin
            state_next = ST_WAIT_BUF;
          end else begin
            state_next = ST_RUN;
            latch_cfg  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (group_end) begin
          if (!ENABLE) begin
            state_next = ST_IDLE;
          end else if (buf_full_reg[pp_other] & ~BUF_RELEASE[pp_other]) begin
            state_next = ST_WAIT_BUF;
          end else begin
            state_next = ST_RUN;
            latch_cfg  = 1'b1;
          end
        end
      end
      ST_WAIT_BUF: begin
        if (BUF_RELEASE[pp_sel_reg] | ~buf_full_reg[pp_sel_reg]) begin
          if (ENABLE) begin
            state_next = ST_RUN;
            latch_cfg  = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    pkt_cnt_next  = pkt_cnt_reg;
    if (group_end) begin
      beat_cnt_next = 32'd0;
      pkt_cnt_next  = 32'd0;
    end else if (last_beat) begin
      beat_cnt_next = 32'd0;
      pkt_cnt_next  = pkt_cnt_reg + 32'd1;
    end else if (beat) begin
      beat_cnt_next = beat_cnt_reg + 32'd1;
    end
    size_lat_next = latch_cfg ? size_in : size_lat_reg;
    grp_lat_next  = latch_cfg ? grp_in : grp_lat_reg;
    pp_sel_next   = pp_sel_reg ^ group_end;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      beat_cnt_reg   <= 32'd0;
      pkt_cnt_reg    <= 32'd0;
      size_lat_reg   <= 32'd1;
      grp_lat_reg    <= 32'd1;
      pp_sel_reg     <= 1'b0;
      buf_full_reg   <= 2'b00;
      group_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_cnt_reg   <= beat_cnt_next;
      pkt_cnt_reg    <= pkt_cnt_next;
      size_lat_reg   <= size_lat_next;
      grp_lat_reg    <= grp_lat_next;
      pp_sel_reg     <= pp_sel_next;
      buf_full_reg   <= buf_full_next;
      group_done_reg <= group_end;
    end
  end

  assign PP_SEL     = pp_sel_reg;
  assign BUF_FULL   = buf_full_reg;
  assign GROUP_DONE = group_done_reg;
  assign BUSY       = (state_reg != ST_IDLE);

endmodule

// File: doc/packet_group_sequencer.md
# packet_group_sequencer

Sequences the streaming datapath using the PACKET_SIZE and PP_GROUP values published by the AXI configuration block. It passes an AXI-Stream of DW-bit beats from the data source to the ping-pong capture buffers and inserts TLAST every PACKET_SIZE beats. It also counts PP_GROUP packets per buffer and alternates between buffer 0 and buffer 1. It stalls the source when both buffers are full and software has not released either one.

## Interface

- DW, 32, stream data width in bits
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- PACKET_SIZE  in  32  beats per packet; 0 treated as 1
- PP_GROUP  in  32  packets per ping-pong buffer; 0 treated as 1
- ENABLE  in  1  run request, level-sensitive
- BUF_RELEASE  in  2  one-cycle pulse per bit; software has drained buffer[i]
- S_AXIS_TDATA  in  DW  source data
- S_AXIS_TVALID  in  1  source valid
- S_AXIS_TREADY  out  1  ready to source
- M_AXIS_TDATA  out  DW  data to buffers
- M_AXIS_TVALID  out  1  valid to buffers
- M_AXIS_TLAST  out  1  last beat of packet
- M_AXIS_TREADY  in  1  buffer ready
- PP_SEL  out  1  buffer currently being filled
- BUF_FULL  out  2  buffer[i] holds a completed, unreleased group
- GROUP_DONE  out  1  one-cycle pulse after the last beat of a group
- BUSY  out  1  state != IDLE

## Operation

- **States.**
  - IDLE → RUN when ENABLE=1.
  - RUN → WAIT_BUF / RUN / IDLE at the end of a group.
  - WAIT_BUF → RUN when the selected buffer is free.
  - Any state → IDLE on reset.
- **Config latching.** size_lat = max(PACKET_SIZE,1) and grp_lat = max(PP_GROUP,1) are latched on every entry to RUN. Changing the inputs mid-group has no effect until the next group.
- **Datapath.** Combinational, zero latency.
  - M_AXIS_TDATA = S_AXIS_TDATA.
  - M_AXIS_TVALID = S_AXIS_TVALID & run.
  - S_AXIS_TREADY = M_AXIS_TREADY & run, where run = (state==RUN).
- **Beat.** A beat is M_AXIS_TVALID & M_AXIS_TREADY.
- **Counters.**
  - beat_cnt (32b) increments per beat and clears on the last beat of a packet.
  - M_AXIS_TLAST = run & (beat_cnt == size_lat-1).
  - pkt_cnt (32b) increments on each TLAST beat. The group ends on the TLAST beat with pkt_cnt == grp_lat-1.
- **End of group.** All updates take effect on the edge of the final beat.
  - BUF_FULL[PP_SEL] is set, PP_SEL toggles, both counters clear, and GROUP_DONE is asserted for the next cycle.
  - Next state:
    - IDLE if ENABLE=0.
    - WAIT_BUF if the new buffer is full and is not released on the same edge.
    - Otherwise RUN, with config re-latched.
- **ENABLE.** Sampled only in IDLE and at group boundaries. Deasserting ENABLE mid-group lets the group complete.
- **BUF_RELEASE[i].**
  - Clears BUF_FULL[i].
  - Is ignored if BUF_FULL[i] is already 0.
  - If a set and a release hit the same bit on the same edge, the set wins.
- **WAIT_BUF.** Exits to RUN on the edge where BUF_RELEASE[PP_SEL]=1, or when BUF_FULL[PP_SEL]=0. If ENABLE=0 at that point, exits to IDLE instead.
- **IDLE.** PP_SEL and BUF_FULL are retained, so they are not reset by ENABLE cycling. On IDLE→RUN, if BUF_FULL[PP_SEL]=1, the block goes to WAIT_BUF instead.

## Timing

- **Reset values.** While resetn=0, at the clock edge: state=IDLE, all counters=0, PP_SEL=0, BUF_FULL=2'b00, GROUP_DONE=0, BUSY=0, S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0.
- **Reset mid-packet.** The partial packet is abandoned with no TLAST. The next packet starts from beat 0 in buffer 0.
- **Start latency.** ENABLE rising in IDLE at edge N: state=RUN, BUSY=1 and S_AXIS_TREADY can be high in cycle N+1.
- **Data latency.** 0 cycles source→sink. TLAST is valid combinationally in the same cycle as its beat.
- **Back-pressure.** While M_AXIS_TREADY=0 or S_AXIS_TVALID=0, the counters hold and TLAST stays stable.
- **Group-boundary gap.** If the next buffer is free, there is no dead cycle between groups: the first beat of the next group may occur in the cycle after the final beat.
- **GROUP_DONE.** Exactly one cycle wide, one per completed group. It is asserted in the cycle after the final beat.
- **Counter width.** No wrap: a latched value of 0xFFFFFFFF is honoured exactly.

## Test plan

- **Basic packetisation.** PACKET_SIZE=4, PP_GROUP=2, ENABLE=1, source and sink always ready, 8 beats → TLAST on beats 4 and 8; GROUP_DONE the cycle after beat 8; PP_SEL 0→1; BUF_FULL=01.
- **Both buffers full.** Same config, 16 beats, no release → BUF_FULL=11, state WAIT_BUF, S_AXIS_TREADY=0. Pulse BUF_RELEASE=01 → RUN next cycle with PP_SEL=0, beat 17 accepted.
- **Zero config and mid-group change.** PACKET_SIZE=0, PP_GROUP=0 → TLAST and GROUP_DONE on every beat, PP_SEL toggles each beat. Change PACKET_SIZE from 4 to 2 mid-group → the current group keeps 4-beat packets; the next group uses 2.
- **Random back-pressure.** Random TVALID/TREADY, PACKET_SIZE=5, PP_GROUP=3, 30 beats → TLAST exactly on beats 5,10,…,30; data order preserved; exactly two GROUP_DONE pulses.
- **ENABLE drop and simultaneous events.** Drop ENABLE after beat 2 of a 4×2 group → all 8 beats still pass, then IDLE with BUSY=0. Also check that a release and a group completion targeting the same bit on the same edge leave BUF_FULL set.
- **Reset mid-packet.** resetn=0 for one cycle after beat 3 of PACKET_SIZE=4 → all outputs at reset values. With ENABLE held, the next TLAST arrives on the 4th beat after restart, in buffer 0.
